host_rx_ts_tagger: RTL and testbench
====================================

Name: host_rx_ts_tagger

Overview:
Timestamp-tagging descriptor buffer in the host receive path. It consumes the free-running 19-bit 4 ms receive timer (8 ns tick, period 500000). Each incoming host frame descriptor is stamped on arrival and held in a small FIFO. At dequeue the block computes the wrap-corrected residence time. Stale descriptors (past the timeout, or aged a full timer period) are discarded and counted before they reach the downstream stage.

Parameters:
DESC_W, 64, descriptor width in bits
DEPTH, 4, FIFO entries (power of 2, minimum 2)
TIMER_MAX, 499999, terminal value of the receive timer; period = TIMER_MAX+1
TIMEOUT, 125000, residence (ticks) at or above which a head entry is dropped (1 ms); a value greater than TIMER_MAX disables the timeout

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
iv_timer  in  19  current receive timer value, 0..TIMER_MAX
i_desc_wr  in  1  descriptor write strobe, one cycle per descriptor
iv_desc  in  DESC_W  descriptor data, valid with i_desc_wr
o_desc_full  out  1  FIFO full (count == DEPTH)
o_desc_valid  out  1  output descriptor valid
ov_desc  out  DESC_W  output descriptor
ov_residence  out  19  residence ticks of ov_desc
i_desc_ack  in  1  downstream accepts the output descriptor
ov_timeout_cnt  out  16  dropped-by-timeout/aging count, saturating
ov_overflow_cnt  out  16  writes lost while full, saturating

Behaviour:
- Reset (async, i_rst_n low): FIFO empty; all armed/aged flags clear; FSM = S_IDLE.
- Reset values of outputs: o_desc_valid=0, ov_desc=0, ov_residence=0, both counters 0, o_desc_full=0.
- Reset mid-operation discards all entries and any pending output with no further side effects.
- Write: on i_desc_wr with count<DEPTH, store {iv_desc, iv_timer} at the write pointer. The stamp is the timer value in the strobe cycle. The entry is visible next cycle.
- Write while full (count==DEPTH, pop in the same cycle not considered): the write is ignored and ov_overflow_cnt increments, saturating at 0xFFFF.
- Simultaneous write and pop: both occur and count is unchanged. This is legal when full only if the pop is in the same cycle; o_desc_full is still 1 in that cycle, so the write is dropped.
- Aging, per entry:
  - Armed bit sets the cycle after the write.
  - Aged bit sets when armed && iv_timer == stamp, meaning exactly one period has elapsed.
  - Both bits clear on pop.
- Residence: r = now - stamp if now >= stamp, else now + TIMER_MAX + 1 - stamp.
  - now = iv_timer in the S_EVAL cycle.
  - 20-bit intermediate, truncated to 19 bits; result is always <= TIMER_MAX.
- FSM:
  - S_IDLE: if FIFO not empty, go to S_EVAL.
  - S_EVAL: pop the head.
    - If aged, or r >= TIMEOUT: increment ov_timeout_cnt (saturating) and return to S_IDLE.
    - Else: load ov_desc = head data and ov_residence = r, set o_desc_valid=1, go to S_OUT.
  - S_OUT: hold ov_desc, ov_residence and o_desc_valid stable. On i_desc_ack, clear o_desc_valid and go to S_IDLE.
  - i_desc_ack outside S_OUT is ignored.
- Latency: write in cycle N, S_EVAL in N+2, o_desc_valid high in N+3. Sustained throughput is one descriptor per 3 cycles with immediate ack.
- Timer discontinuities: if the timer is reset externally while entries are queued, residence and aging for those entries are unspecified. Software resets the timer only with the FIFO empty.
- Counters never wrap; they are cleared only by reset.

Test Plan:
1. Basic latency: write at iv_timer=100 with ack tied high -> o_desc_valid high 3 cycles later with ov_residence=2, ov_desc equal to the written data; counters stay 0.
2. Wrap-around: write at iv_timer=499999 -> S_EVAL sees iv_timer=1 -> ov_residence=2, no drop.
3. Timeout: write A at t=0 and B at t=1, ack withheld for 130000 cycles after A is presented, then ack -> A delivered; B dropped in S_EVAL; ov_timeout_cnt=1; o_desc_valid stays 0.
4. Aging: TIMEOUT=500001, write A and B, hold A un-acked for 500005 cycles, then ack -> B aged and dropped; ov_timeout_cnt=1.
5. Overflow: ack held low, 6 writes back-to-back -> first entry moves to output, 4 stay buffered, o_desc_full=1, 6th write lost, ov_overflow_cnt=1. Then 5 acks spaced out -> 5 descriptors delivered in write order.
6. Reset mid-operation: assert i_rst_n low while in S_OUT with 3 queued -> all outputs 0 immediately; after release, no descriptors emitted without new writes.

Source files
------------

// File: rtl/host_rx_ts_tagger_if.sv
// ---------------------------------------------------------------------------
// host_rx_ts_tagger_if
//   Bundles the receive-timer input, the descriptor write side, the
//   descriptor output handshake and the drop/overflow statistics of
//   host_rx_ts_tagger.
//
//   master : the host side (drives timer, descriptor writes and acks)
//   slave  : the tagger itself
//
//   timer        19      current receive timer value, 0..TIMER_MAX
//   desc_wr      1       descriptor write strobe, one cycle per descriptor
//   desc         DESC_W  descriptor data, valid with desc_wr
//   desc_full    1       FIFO full
//   desc_valid   1       output descriptor valid
//   desc_out     DESC_W  output descriptor
//   residence    19      residence ticks of desc_out
//   desc_ack     1       downstream accepts the output descriptor
//   timeout_cnt  16      dropped-by-timeout/aging count, saturating
//   overflow_cnt 16      writes lost while full, saturating
// ---------------------------------------------------------------------------
interface host_rx_ts_tagger_if #(
  parameter int DESC_W = 64
);
  logic [18:0]       timer;
  logic              desc_wr;
  logic [DESC_W-1:0] desc;
  logic              desc_full;
  logic              desc_valid;
  logic [DESC_W-1:0] desc_out;
  logic [18:0]       residence;
  logic              desc_ack;
  logic [15:0]       timeout_cnt;
  logic [15:0]       overflow_cnt;

  modport master (
    output timer, desc_wr, desc, desc_ack,
    input  desc_full, desc_valid, desc_out, residence, timeout_cnt, overflow_cnt
  );

  modport slave (
    input  timer, desc_wr, desc, desc_ack,
    output desc_full, desc_valid, desc_out, residence, timeout_cnt, overflow_cnt
  );
endinterface

// File: rtl/host_rx_ts_tagger.sv
// ---------------------------------------------------------------------------
// host_rx_ts_tagger
//   Timestamp-tagging descriptor buffer for the host receive path. Every
//   written descriptor is stamped with the free-running receive timer and
//   queued. When the head is evaluated, its wrap-corrected residence time is
//   computed; entries that reached the timeout, or that sat a full timer
//   period (aged), are discarded and counted instead of being presented.
//
//   i_clk    clock
//   i_rst_n  asynchronous active-low reset
//   bus      host_rx_ts_tagger_if.slave (timer, write side, output
//            handshake, statistics counters)
// ---------------------------------------------------------------------------
module host_rx_ts_tagger #(
  parameter int          DESC_W    = 64,
  parameter int          DEPTH     = 4,
  parameter int unsigned TIMER_MAX = 499999,
  parameter int unsigned TIMEOUT   = 125000
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  host_rx_ts_tagger_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EVAL,
    S_OUT
  } state_t;

  state_t state, state_nxt;

  // Entry storage
  logic [DESC_W-1:0] mem_desc  [DEPTH];
  logic [18:0]       mem_stamp [DEPTH];
  logic [DEPTH-1:0]  written;   // entry holds a descriptor
  logic [DEPTH-1:0]  armed;     // set the cycle after the write
  logic [DEPTH-1:0]  aged;      // timer came back round to the stamp

  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;

  logic              full, empty;
  logic              wr_accept, wr_drop;
  logic              pop, drop, load, out_valid;

  logic [DESC_W-1:0] desc_q;
  logic [18:0]       residence_q;
  logic [15:0]       timeout_cnt_q, overflow_cnt_q;

  logic [19:0]       now_ext, stamp_ext, res_full;
  logic [18:0]       res_now;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  // A pop in the same cycle does not free a slot for the write.
  assign wr_accept = bus.desc_wr && !full;
  assign wr_drop   = bus.desc_wr && full;

  // Wrap-corrected residence of the head, evaluated against the live timer.
  always_comb begin
    now_ext   = {1'b0, bus.timer};
    stamp_ext = {1'b0, mem_stamp[rd_ptr]};
    if (now_ext >= stamp_ext)
      res_full = now_ext - stamp_ext;
    else
      res_full = now_ext + 20'(TIMER_MAX) + 20'd1 - stamp_ext;
  end
  assign res_now = res_full[18:0];

  // ---------------------------------------------------------------- FSM
  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples values from before the edge regardless of process order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // NOTE: each combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (!empty) state_nxt = S_EVAL;
      S_EVAL: state_nxt = drop ? S_IDLE : S_OUT;
      S_OUT:  if (bus.desc_ack) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    pop       = (state == S_EVAL);
    drop      = pop && (aged[rd_ptr] || (32'(res_now) >= TIMEOUT));
    load      = pop && !drop;
    out_valid = (state == S_OUT);
  end

  // ---------------------------------------------------------------- storage
  // NOTE: the data/stamp array has no reset; occupancy is tracked by the
  // reset pointers and flags, so stale contents are never observed.
  always_ff @(posedge i_clk) begin
    if (wr_accept) begin
      mem_desc[wr_ptr]  <= bus.desc;
      mem_stamp[wr_ptr] <= bus.timer;
    end
  end

  // Per-entry flags. A popped slot is never the write slot in the same
  // cycle: writes are only accepted below DEPTH, when the write slot is free.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      written <= '0;
      armed   <= '0;
      aged    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (pop && (rd_ptr == PTR_W'(i))) begin
          written[i] <= 1'b0;
          armed[i]   <= 1'b0;
          aged[i]    <= 1'b0;
        end else begin
          if (wr_accept && (wr_ptr == PTR_W'(i))) written[i] <= 1'b1;
          if (written[i]) armed[i] <= 1'b1;
          // Only meaningful once armed: in the write cycle itself the timer
          // trivially equals the stamp.
          if (armed[i] && (bus.timer == mem_stamp[i])) aged[i] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)       rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({wr_accept, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------- output
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      desc_q      <= '0;
      residence_q <= '0;
    end else if (load) begin
      desc_q      <= mem_desc[rd_ptr];
      residence_q <= res_now;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      timeout_cnt_q  <= '0;
      overflow_cnt_q <= '0;
    end else begin
      if (drop && (timeout_cnt_q != 16'hFFFF))
        timeout_cnt_q <= timeout_cnt_q + 16'd1;
      if (wr_drop && (overflow_cnt_q != 16'hFFFF))
        overflow_cnt_q <= overflow_cnt_q + 16'd1;
    end
  end

  assign bus.desc_full    = full;
  assign bus.desc_valid   = out_valid;
  assign bus.desc_out     = desc_q;
  assign bus.residence    = residence_q;
  assign bus.timeout_cnt  = timeout_cnt_q;
  assign bus.overflow_cnt = overflow_cnt_q;

endmodule

// File: tb/tb_host_rx_ts_tagger.sv
// ---------------------------------------------------------------------------
// tb_host_rx_ts_tagger
//   Directed bench for host_rx_ts_tagger. The receive timer is driven by the
//   bench: it advances one tick per clock and is moved forward in jumps where
//   long waits would otherwise take hundreds of thousands of cycles. Jumps
//   never cross the stamp of a queued entry unless crossing it is the point.
// ---------------------------------------------------------------------------
module tb_host_rx_ts_tagger;

  localparam logic [18:0] TMAX = 19'd499999;

  logic        clk;
  logic        rst_n;
  logic [18:0] tmr;
  int          n_checks;
  int          n_pass;

  host_rx_ts_tagger_if #(.DESC_W(64)) bus ();

  assign bus.timer = tmr;

  host_rx_ts_tagger #(
    .DESC_W    (64),
    .DEPTH     (4),
    .TIMER_MAX (499999),
    .TIMEOUT   (125000)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One clock: outputs are sampled 1 time unit after the edge, then the
  // timer advances for the next cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    tmr = (tmr == TMAX) ? 19'd0 : tmr + 19'd1;
  endtask

  task automatic push(input logic [63:0] d);
    bus.desc_wr = 1'b1;
    bus.desc    = d;
    tick();
    bus.desc_wr = 1'b0;
  endtask

  task automatic ack_once();
    bus.desc_ack = 1'b1;
    tick();
    bus.desc_ack = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n;
    n = 0;
    while (bus.desc_valid !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check(tag, 64'(bus.desc_valid), 64'd1);
  endtask

  // Watches desc_valid for n cycles and checks it never rises.
  task automatic expect_quiet(input string tag, input int n);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (bus.desc_valid !== 1'b0) seen = 1'b1;
    end
    check(tag, 64'(seen), 64'd0);
  endtask

  task automatic do_reset();
    bus.desc_wr  = 1'b0;
    bus.desc_ack = 1'b0;
    rst_n        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks     = 0;
    n_pass       = 0;
    rst_n        = 1'b0;
    tmr          = 19'd0;
    bus.desc_wr  = 1'b0;
    bus.desc     = '0;
    bus.desc_ack = 1'b0;

    // ---------------- reset state
    @(posedge clk);
    #1;
    check("rst_valid",    64'(bus.desc_valid),   64'd0);
    check("rst_desc",     bus.desc_out,          64'd0);
    check("rst_res",      64'(bus.residence),    64'd0);
    check("rst_full",     64'(bus.desc_full),    64'd0);
    check("rst_tmo_cnt",  64'(bus.timeout_cnt),  64'd0);
    check("rst_ovf_cnt",  64'(bus.overflow_cnt), 64'd0);
    do_reset();

    // ---------------- 1: basic latency, ack tied high
    bus.desc_ack = 1'b1;
    tmr = 19'd100;
    push(64'h1111_2222_3333_4444);        // stamp 100
    tick();                                // now in S_EVAL (timer 102)
    check("t1_not_early", 64'(bus.desc_valid), 64'd0);
    tick();
    check("t1_valid",     64'(bus.desc_valid), 64'd1);
    check("t1_desc",      bus.desc_out,        64'h1111_2222_3333_4444);
    check("t1_res",       64'(bus.residence),  64'd2);
    tick();
    check("t1_acked",     64'(bus.desc_valid), 64'd0);
    check("t1_tmo_cnt",   64'(bus.timeout_cnt),  64'd0);
    check("t1_ovf_cnt",   64'(bus.overflow_cnt), 64'd0);

    // ---------------- 2: wrap-around (stamp 499999, evaluated at 1)
    tmr = TMAX;
    push(64'hAAAA_0000_0000_0002);
    tick();
    tick();
    check("t2_valid",   64'(bus.desc_valid), 64'd1);
    check("t2_desc",    bus.desc_out,        64'hAAAA_0000_0000_0002);
    check("t2_res",     64'(bus.residence),  64'd2);
    tick();
    check("t2_tmo_cnt", 64'(bus.timeout_cnt), 64'd0);

    // ---------------- timeout boundary: 124999 kept, 125000 dropped
    tmr = 19'd10;
    push(64'hB0B0_0000_0000_0001);
    tick();
    tmr = 19'd125009;                      // S_EVAL sees residence 124999
    tick();
    check("bnd_keep_valid", 64'(bus.desc_valid), 64'd1);
    check("bnd_keep_res",   64'(bus.residence),  64'd124999);
    tick();                                // acked
    tmr = 19'd10;
    push(64'hB0B0_0000_0000_0002);
    tick();
    tmr = 19'd125010;                      // S_EVAL sees residence 125000
    tick();
    check("bnd_drop_valid", 64'(bus.desc_valid),  64'd0);
    check("bnd_drop_cnt",   64'(bus.timeout_cnt), 64'd1);
    expect_quiet("bnd_drop_quiet", 4);

    // ---------------- 3: timeout while head is held
    do_reset();
    check("t3_rst_cnt", 64'(bus.timeout_cnt), 64'd0);
    tmr = 19'd0;
    push(64'hA3A3_A3A3_0000_0000);         // stamp 0
    push(64'hB3B3_B3B3_0000_0000);         // stamp 1
    tick();
    check("t3_a_valid", 64'(bus.desc_valid), 64'd1);
    check("t3_a_res",   64'(bus.residence),  64'd2);
    tmr = 19'd130000;
    repeat (5) tick();
    check("t3_a_hold_desc", bus.desc_out,       64'hA3A3_A3A3_0000_0000);
    check("t3_a_hold_res",  64'(bus.residence), 64'd2);
    ack_once();
    check("t3_ack_clears", 64'(bus.desc_valid), 64'd0);
    expect_quiet("t3_b_not_presented", 6);
    check("t3_tmo_cnt", 64'(bus.timeout_cnt), 64'd1);
    check("t3_empty",   64'(bus.desc_full),   64'd0);

    // ---------------- 4: aging (B waits a full period, small residence)
    do_reset();
    tmr = 19'd0;
    push(64'hA4A4_0000_0000_0000);         // stamp 0
    push(64'hB4B4_0000_0000_0000);         // stamp 1
    tick();
    tmr = 19'd499990;                      // wait crosses 0 and then 1 again
    repeat (15) tick();
    check("t4_a_valid", 64'(bus.desc_valid), 64'd1);
    check("t4_a_desc",  bus.desc_out,        64'hA4A4_0000_0000_0000);
    ack_once();
    expect_quiet("t4_b_aged_quiet", 6);
    check("t4_tmo_cnt", 64'(bus.timeout_cnt), 64'd1);

    // ---------------- 5: overflow and in-order drain
    do_reset();
    for (int k = 0; k < 6; k++) push(64'hD000 + 64'(k));
    check("t5_full",    64'(bus.desc_full),    64'd1);
    check("t5_ovf_cnt", 64'(bus.overflow_cnt), 64'd1);
    check("t5_d0_desc", bus.desc_out,          64'hD000);
    ack_once();                            // S_IDLE, still full
    tick();                                // S_EVAL cycle, still full
    bus.desc_wr = 1'b1;
    bus.desc    = 64'hDEAD;
    tick();                                // pop + write in same cycle
    bus.desc_wr = 1'b0;
    check("t5_ovf_pop_cycle", 64'(bus.overflow_cnt), 64'd2);
    check("t5_d1_valid", 64'(bus.desc_valid), 64'd1);
    check("t5_d1_desc",  bus.desc_out,        64'hD001);
    check("t5_not_full", 64'(bus.desc_full),  64'd0);
    for (int k = 2; k < 5; k++) begin
      tick();
      ack_once();
      wait_valid($sformatf("t5_d%0d_valid", k), 8);
      check($sformatf("t5_d%0d_desc", k), bus.desc_out, 64'hD000 + 64'(k));
    end
    ack_once();
    expect_quiet("t5_drained", 6);
    check("t5_tmo_cnt", 64'(bus.timeout_cnt), 64'd0);

    // ---------------- 6: reset in S_OUT with 3 queued
    do_reset();
    for (int k = 0; k < 4; k++) push(64'hE000 + 64'(k));
    check("t6_pre_valid", 64'(bus.desc_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 64'(bus.desc_valid), 64'd0);
    check("t6_rst_desc",  bus.desc_out,        64'd0);
    check("t6_rst_res",   64'(bus.residence),  64'd0);
    check("t6_rst_full",  64'(bus.desc_full),  64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.desc_ack = 1'b1;                   // ignored outside S_OUT
    expect_quiet("t6_no_ghosts", 12);
    check("t6_tmo_cnt", 64'(bus.timeout_cnt), 64'd0);
    push(64'hF00D);
    wait_valid("t6_new_valid", 6);
    check("t6_new_desc", bus.desc_out, 64'hF00D);
    bus.desc_ack = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
